mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 57 +++++
 rtl/mem_access_unit_load_align.sv | 31 +++
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: op codes, control flag
// values, access sizes and the op decoder used by the top level.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_LL      = 6'h30;
  localparam logic [5:0] OP_SC      = 6'h38;
  localparam logic [5:0] OP_SYSCALL = 6'h3C;
  localparam logic [5:0] OP_ERET    = 6'h3D;

  localparam logic RstEnable = 1'b1;
  localparam logic RamWrite  = 1'b1;
  localparam logic RamEnable = 1'b1;
  localparam logic SetFlag   = 1'b1;
  localparam logic ClearFlag = 1'b0;

  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic  mem;
    logic  load;
    logic  store;
    logic  sext;
    logic  ll;
    logic  sc;
    logic  clr;
    size_t size;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_LB:   begin d.mem = 1'b1; d.load = 1'b1; d.sext = 1'b1; d.size = SZ_B; end
      OP_LBU:  begin d.mem = 1'b1; d.load = 1'b1; d.size = SZ_B; end
      OP_LH:   begin d.mem = 1'b1; d.load = 1'b1; d.sext = 1'b1; d.size = SZ_H; end
      OP_LHU:  begin d.mem = 1'b1; d.load = 1'b1; d.size = SZ_H; end
      OP_LW:   begin d.mem = 1'b1; d.load = 1'b1; d.size = SZ_W; end
      OP_LL:   begin d.mem = 1'b1; d.load = 1'b1; d.ll = 1'b1; d.size = SZ_W; end
      OP_SB:   begin d.mem = 1'b1; d.store = 1'b1; d.size = SZ_B; end
      OP_SH:   begin d.mem = 1'b1; d.store = 1'b1; d.size = SZ_H; end
      OP_SW:   begin d.mem = 1'b1; d.store = 1'b1; d.size = SZ_W; end
      OP_SC:   begin d.mem = 1'b1; d.store = 1'b1; d.sc = 1'b1; d.size = SZ_W; end
      OP_SYSCALL, OP_ERET: d.clr = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load lane selection with sign or zero extension of byte/half results.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  size_t       i_size,
  input  logic        i_sext,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  // Pick the addressed byte/half lane and extend it to 32 bits
  always_comb begin
    case (i_lane)
      2'd0:    w_b = i_rdata[7:0];
      2'd1:    w_b = i_rdata[15:8];
      2'd2:    w_b = i_rdata[23:16];
      default: w_b = i_rdata[31:24];
    endcase
    w_h = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_B:    o_data = {{24{i_sext & w_b[7]}}, w_b};
      SZ_H:    o_data = {{16{i_sext & w_h[15]}}, w_h};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: issues load/store requests, aligns load data,
// tracks the LL/SC link flag and raises alignment/bus-error pulses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned TMO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [5:0]    op,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [31:0]   mem_data,
  input  logic [31:0]   regc_data,
  input  logic [4:0]    regc_addr,
  input  logic          regc_wr,
  input  logic          flush,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          stall,
  output logic          out_valid,
  output logic [4:0]    reg_addr,
  output logic          reg_wr,
  output logic [31:0]   reg_data,
  output logic          excp_align,
  output logic          excp_bus,
  output logic          llbit
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t        r_state;
  logic [31:0]   r_cnt;
  logic          r_load, r_store, r_sext, r_ll, r_sc;
  size_t         r_size;
  logic [4:0]    r_regc_addr;
  logic          r_regc_wr;
  logic          r_flushed;
  logic [AW-1:2] r_link;

  dec_t        w_dec;
  logic        w_misalign;
  logic        w_sc_ok;
  logic        w_link_hit;
  logic        w_kill;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  assign w_dec      = decode(op);
  assign stall      = (r_state == S_REQ);
  assign w_sc_ok    = llbit && (mem_addr_i[AW-1:2] == r_link);
  assign w_link_hit = (mem_addr[AW-1:2] == r_link);
  assign w_kill     = r_flushed || flush;

  // Alignment check, byte enables and lane-replicated store data
  always_comb begin
    w_misalign = 1'b0;
    w_be       = '0;
    w_wdata    = '0;
    case (w_dec.size)
      SZ_W: begin
        w_misalign = |mem_addr_i[1:0];
        w_be       = 4'b1111;
        w_wdata    = mem_data;
      end
      SZ_H: begin
        w_misalign = mem_addr_i[0];
        w_be       = 4'b0011 << {mem_addr_i[1], 1'b0};
        w_wdata    = {2{mem_data[15:0]}};
      end
      SZ_B: begin
        w_be       = 4'b0001 << mem_addr_i[1:0];
        w_wdata    = {4{mem_data[7:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .i_rdata (mem_rdata),
    .i_lane  (mem_addr[1:0]),
    .i_size  (r_size),
    .i_sext  (r_sext),
    .o_data  (w_load)
  );

  // Request FSM with registered write-back, exception pulses and link state
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_sext      <= 1'b0;
      r_ll        <= 1'b0;
      r_sc        <= 1'b0;
      r_size      <= SZ_NONE;
      r_regc_addr <= '0;
      r_regc_wr   <= 1'b0;
      r_flushed   <= 1'b0;
      r_link      <= '0;
      llbit       <= ClearFlag;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      out_valid   <= 1'b0;
      reg_addr    <= '0;
      reg_wr      <= 1'b0;
      reg_data    <= '0;
      excp_align  <= 1'b0;
      excp_bus    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      excp_align <= 1'b0;
      excp_bus   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            reg_addr <= regc_addr;
            if (w_dec.mem && w_misalign) begin
              out_valid  <= 1'b1;
              excp_align <= 1'b1;
              reg_wr     <= 1'b0;
              reg_data   <= '0;
            end else if (w_dec.sc && !w_sc_ok) begin
              out_valid <= 1'b1;
              reg_wr    <= regc_wr;
              reg_data  <= '0;
            end else if (w_dec.mem) begin
              r_state     <= S_REQ;
              r_cnt       <= '0;
              r_load      <= w_dec.load;
              r_store     <= w_dec.store;
              r_sext      <= w_dec.sext;
              r_ll        <= w_dec.ll;
              r_sc        <= w_dec.sc;
              r_size      <= w_dec.size;
              r_regc_addr <= regc_addr;
              r_regc_wr   <= regc_wr;
              r_flushed   <= 1'b0;
              mem_req     <= RamEnable;
              mem_we      <= w_dec.store ? RamWrite : !RamWrite;
              mem_be      <= w_be;
              mem_addr    <= mem_addr_i;
              mem_wdata   <= w_wdata;
            end else if (w_dec.clr) begin
              out_valid <= 1'b1;
              reg_wr    <= 1'b0;
              reg_data  <= '0;
            end else begin
              out_valid <= 1'b1;
              reg_wr    <= regc_wr;
              reg_data  <= regc_data;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_state   <= S_IDLE;
            mem_req   <= 1'b0;
            out_valid <= !w_kill;
            reg_addr  <= r_regc_addr;
            reg_wr    <= (r_load || r_sc) && r_regc_wr && !w_kill;
            reg_data  <= r_sc ? 32'd1 : (r_load ? w_load : '0);
            if (r_ll && !r_flushed) begin
              llbit  <= SetFlag;
              r_link <= mem_addr[AW-1:2];
            end
            if (r_store && w_link_hit)
              llbit <= ClearFlag;
          end else if (TMO != 0 && r_cnt == TMO - 1) begin
            r_state   <= S_IDLE;
            mem_req   <= 1'b0;
            excp_bus  <= 1'b1;
            out_valid <= !w_kill;
            reg_wr    <= 1'b0;
            reg_data  <= '0;
          end else begin
            r_cnt <= r_cnt + 1;
          end
          if (flush)
            r_flushed <= 1'b1;
        end
      endcase
      // Placed last so a clear always overrides an LL completion in the same cycle
      if (flush || (r_state == S_IDLE && in_valid && w_dec.clr))
        llbit <= ClearFlag;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, regc_wr, flush, mem_ack;
  logic [5:0]  op;
  logic [31:0] mem_addr_i, mem_data, regc_data, mem_rdata;
  logic [4:0]  regc_addr;
  logic        mem_req, mem_we, stall, out_valid, reg_wr, excp_align, excp_bus, llbit;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, reg_data;
  logic [4:0]  reg_addr;

  int total = 0;
  int bad   = 0;
  bit          ref_ll;
  logic [31:0] ref_link;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(32), .TMO(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .mem_addr_i(mem_addr_i),
    .mem_data(mem_data), .regc_data(regc_data), .regc_addr(regc_addr), .regc_wr(regc_wr),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .out_valid(out_valid), .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_data(reg_data),
    .excp_align(excp_align), .excp_bus(excp_bus), .llbit(llbit)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [5:0] o);
    case (o)
      OP_LW, OP_SW, OP_LL, OP_SC: return 4;
      OP_LH, OP_LHU, OP_SH:       return 2;
      OP_LB, OP_LBU, OP_SB:       return 1;
      default:                    return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [5:0] o);
    return o == OP_LW || o == OP_LH || o == OP_LHU || o == OP_LB || o == OP_LBU || o == OP_LL;
  endfunction

  function automatic bit is_store(input logic [5:0] o);
    return o == OP_SW || o == OP_SH || o == OP_SB || o == OP_SC;
  endfunction

  function automatic logic [3:0] ref_be(input logic [5:0] o, input logic [31:0] a);
    int v;
    v = ((1 << nbytes(o)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [5:0] o, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = nbytes(o);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] o, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint unsigned v, lim;
    int n;
    n   = nbytes(o);
    lim = 64'd1 << (8 * n);
    v   = (64'(rd) >> (8 * (a % 4))) % lim;
    if ((o == OP_LB || o == OP_LH) && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] cd, input logic [4:0] ra, input logic rw);
    @(negedge clk);
    in_valid = 1'b1; op = o; mem_addr_i = a; mem_data = d;
    regc_data = cd; regc_addr = ra; regc_wr = rw;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ack(input int n, input logic [31:0] rd, output int stalls);
    stalls = 0;
    for (int k = 1; k <= n; k++) begin
      if (stall) stalls++;
      if (k == n) begin mem_ack = 1'b1; mem_rdata = rd; end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; op = OP_LW; mem_addr_i = 32'h100; mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; mem_ack = 1'b0;
    total++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin bad++;
      $display("FAIL reset_mem got=%b/%b/%h/%h/%h want=0", mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
    total++; if ({stall, out_valid, reg_addr, reg_wr, reg_data} !== '0) begin bad++;
      $display("FAIL reset_wb got=%b/%b/%h/%b/%h want=0", stall, out_valid, reg_addr, reg_wr, reg_data); end
    total++; if ({excp_align, excp_bus, llbit} !== 3'b000) begin bad++;
      $display("FAIL reset_flags got=%b%b%b want=000", excp_align, excp_bus, llbit); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0 || out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_idle got stall=%b ov=%b want 0/0", stall, out_valid); end
    ref_ll = 1'b0; ref_link = '0;
  endtask

  task automatic test_passthrough();
    logic [31:0] cd; logic [4:0] ra; logic rw; logic [5:0] o;
    for (int i = 0; i < 6; i++) begin
      o = 6'($urandom_range(0, 15)); cd = $urandom; ra = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      drive_op(o, $urandom, $urandom, cd, ra, rw);
      total++; if (out_valid !== 1'b1 || mem_req !== 1'b0) begin bad++;
        $display("FAIL pass_valid got ov=%b req=%b want 1/0", out_valid, mem_req); end
      total++; if (reg_data !== cd || reg_addr !== ra || reg_wr !== rw) begin bad++;
        $display("FAIL pass_wb got %h/%0d/%b want %h/%0d/%b", reg_data, reg_addr, reg_wr, cd, ra, rw); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++;
        $display("FAIL pass_pulse got ov=%b want 0", out_valid); end
    end
  endtask

  task automatic test_lb_lane();
    int st;
    drive_op(OP_LB, 32'h103, 32'h0, 32'h0, 5'd3, 1'b1);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h103) begin bad++;
      $display("FAIL lb_req got req=%b we=%b addr=%h want 1/0/103", mem_req, mem_we, mem_addr); end
    total++; if (mem_be !== 4'b1000) begin bad++;
      $display("FAIL lb_be got=%b want=1000", mem_be); end
    wait_ack(3, 32'h80FF_FF7F, st);
    total++; if (st !== 3) begin bad++; $display("FAIL lb_stall got=%0d want=3", st); end
    total++; if (out_valid !== 1'b1 || reg_wr !== 1'b1 || reg_addr !== 5'd3 || mem_req !== 1'b0) begin bad++;
      $display("FAIL lb_done got ov=%b wr=%b ra=%0d req=%b want 1/1/3/0", out_valid, reg_wr, reg_addr, mem_req); end
    total++; if (reg_data !== 32'hFFFF_FF80) begin bad++;
      $display("FAIL lb_data got=%h want=ffffff80", reg_data); end
  endtask

  task automatic test_sh_store();
    int st;
    drive_op(OP_SH, 32'h202, 32'h0000_ABCD, 32'h0, 5'd4, 1'b1);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100) begin bad++;
      $display("FAIL sh_req got req=%b we=%b be=%b want 1/1/1100", mem_req, mem_we, mem_be); end
    total++; if (mem_wdata !== 32'hABCD_ABCD) begin bad++;
      $display("FAIL sh_wdata got=%h want=abcdabcd", mem_wdata); end
    wait_ack(2, $urandom, st);
    total++; if (out_valid !== 1'b1 || reg_wr !== 1'b0) begin bad++;
      $display("FAIL sh_done got ov=%b wr=%b want 1/0", out_valid, reg_wr); end
  endtask

  task automatic test_misalign();
    logic [5:0]  ops[6]   = '{OP_LW, OP_LW, OP_SH, OP_LHU, OP_SC, OP_LL};
    logic [31:0] addrs[6] = '{32'h101, 32'h102, 32'h201, 32'h3, 32'h42, 32'h41};
    for (int i = 0; i < 6; i++) begin
      drive_op(ops[i], addrs[i], $urandom, $urandom, 5'd9, 1'b1);
      total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++;
        $display("FAIL mis_noreq[%0d] got req=%b stall=%b want 0/0", i, mem_req, stall); end
      total++; if (excp_align !== 1'b1 || out_valid !== 1'b1 || reg_wr !== 1'b0) begin bad++;
        $display("FAIL mis_excp[%0d] got ex=%b ov=%b wr=%b want 1/1/0", i, excp_align, out_valid, reg_wr); end
      @(negedge clk);
      total++; if (excp_align !== 1'b0) begin bad++;
        $display("FAIL mis_pulse[%0d] got=%b want=0", i, excp_align); end
    end
  endtask

  task automatic test_ll_sc();
    int st;
    drive_op(OP_LL, 32'h40, 32'h0, 32'h0, 5'd7, 1'b1);
    wait_ack(1, 32'h1234_5678, st);
    total++; if (reg_data !== 32'h1234_5678 || llbit !== 1'b1) begin bad++;
      $display("FAIL ll_done got data=%h ll=%b want 12345678/1", reg_data, llbit); end
    drive_op(OP_SC, 32'h40, 32'hCAFE_F00D, 32'h0, 5'd8, 1'b1);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_wdata !== 32'hCAFE_F00D) begin bad++;
      $display("FAIL sc_req got req=%b we=%b be=%b wd=%h want 1/1/1111/cafef00d", mem_req, mem_we, mem_be, mem_wdata); end
    wait_ack(1, 32'h0, st);
    total++; if (reg_data !== 32'd1 || reg_wr !== 1'b1 || llbit !== 1'b0) begin bad++;
      $display("FAIL sc_ok got data=%h wr=%b ll=%b want 1/1/0", reg_data, reg_wr, llbit); end
    drive_op(OP_SC, 32'h40, 32'h5555_5555, 32'h0, 5'd8, 1'b1);
    total++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || reg_data !== 32'd0) begin bad++;
      $display("FAIL sc_fail got req=%b ov=%b data=%h want 0/1/0", mem_req, out_valid, reg_data); end
    // link survives an SC to another word, dies on a byte store into the link word
    drive_op(OP_LL, 32'h40, 32'h0, 32'h0, 5'd7, 1'b1);
    wait_ack(2, 32'h0, st);
    drive_op(OP_SC, 32'h44, 32'h0, 32'h0, 5'd8, 1'b1);
    total++; if (mem_req !== 1'b0 || reg_data !== 32'd0 || llbit !== 1'b1) begin bad++;
      $display("FAIL sc_other got req=%b data=%h ll=%b want 0/0/1", mem_req, reg_data, llbit); end
    drive_op(OP_SB, 32'h43, 32'h0, 32'h0, 5'd0, 1'b0);
    wait_ack(1, 32'h0, st);
    total++; if (llbit !== 1'b0) begin bad++; $display("FAIL sb_link_clear got=%b want=0", llbit); end
    ref_ll = 1'b0;
  endtask

  task automatic test_link_clear();
    int st;
    logic [5:0] clr_ops[2] = '{OP_SYSCALL, OP_ERET};
    for (int i = 0; i < 2; i++) begin
      drive_op(OP_LL, 32'h80, 32'h0, 32'h0, 5'd1, 1'b1);
      wait_ack(1, 32'h0, st);
      drive_op(clr_ops[i], 32'h0, 32'h0, 32'h0, 5'd1, 1'b1);
      total++; if (llbit !== 1'b0 || reg_wr !== 1'b0) begin bad++;
        $display("FAIL op_clear[%0d] got ll=%b wr=%b want 0/0", i, llbit, reg_wr); end
    end
    drive_op(OP_LL, 32'h80, 32'h0, 32'h0, 5'd1, 1'b1);
    wait_ack(1, 32'h0, st);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    total++; if (llbit !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b want=0", llbit); end
    // flush landing on the same edge as an LL completion must leave the flag clear
    drive_op(OP_LL, 32'h60, 32'h0, 32'h0, 5'd1, 1'b1);
    mem_ack = 1'b1; mem_rdata = $urandom; flush = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; flush = 1'b0;
    total++; if (llbit !== 1'b0 || out_valid !== 1'b0) begin bad++;
      $display("FAIL ll_flush_prio got ll=%b ov=%b want 0/0", llbit, out_valid); end
    ref_ll = 1'b0;
  endtask

  task automatic test_flush_req();
    int st;
    drive_op(OP_LW, 32'h300, 32'h0, 32'h0, 5'd2, 1'b1);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    total++; if (stall !== 1'b1 || mem_req !== 1'b1) begin bad++;
      $display("FAIL flush_wait got stall=%b req=%b want 1/1", stall, mem_req); end
    wait_ack(2, 32'hDEAD_BEEF, st);
    total++; if (out_valid !== 1'b0 || reg_wr !== 1'b0 || stall !== 1'b0) begin bad++;
      $display("FAIL flush_suppress got ov=%b wr=%b stall=%b want 0/0/0", out_valid, reg_wr, stall); end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit dropped = 1'b0;
    drive_op(OP_LW, 32'h200, 32'h0, 32'h0, 5'd5, 1'b1);
    while (stall && n < 20) begin
      if (mem_req !== 1'b1 || mem_addr !== 32'h200) dropped = 1'b1;
      n++;
      @(negedge clk);
    end
    total++; if (n != 4) begin bad++; $display("FAIL tmo_cycles got=%0d want=4", n); end
    total++; if (dropped) begin bad++; $display("FAIL tmo_hold got=unstable want=stable"); end
    total++; if (excp_bus !== 1'b1 || out_valid !== 1'b1 || reg_wr !== 1'b0 || mem_req !== 1'b0) begin bad++;
      $display("FAIL tmo_excp got ex=%b ov=%b wr=%b req=%b want 1/1/0/0", excp_bus, out_valid, reg_wr, mem_req); end
    @(negedge clk);
    total++; if (excp_bus !== 1'b0 || out_valid !== 1'b0) begin bad++;
      $display("FAIL tmo_pulse got ex=%b ov=%b want 0/0", excp_bus, out_valid); end
  endtask

  task automatic test_rst_in_req();
    int st;
    drive_op(OP_LL, 32'h40, 32'h0, 32'h0, 5'd7, 1'b1);
    wait_ack(1, 32'h0, st);
    drive_op(OP_LW, 32'h44, 32'h0, 32'h0, 5'd7, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222; rst = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || llbit !== 1'b0 || stall !== 1'b0 || out_valid !== 1'b0) begin bad++;
      $display("FAIL rst_req got req=%b ll=%b stall=%b ov=%b want 0/0/0/0", mem_req, llbit, stall, out_valid); end
    rst = 1'b0; mem_ack = 1'b0;
    ref_ll = 1'b0; ref_link = '0;
  endtask

  task automatic test_random();
    logic [5:0]  ops[11] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, OP_LL, OP_SC, 6'h05};
    logic [5:0]  o;
    logic [31:0] a, d, cd, rd;
    logic [4:0]  ra;
    logic        rw;
    int n, dly, st;
    bit mis, sc_ok, exp_req;
    for (int i = 0; i < 60; i++) begin
      o  = ops[$urandom_range(0, 10)];
      a  = 32'h100 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
      if (o == OP_SC && ref_ll && $urandom_range(0, 1) == 1) a = ref_link;
      d = $urandom; cd = $urandom; rd = $urandom;
      ra = 5'($urandom_range(0, 31)); rw = 1'($urandom_range(0, 1));
      dly = $urandom_range(1, 3);
      n = nbytes(o);
      mis   = (n > 0) && (a % n != 0);
      sc_ok = (o == OP_SC) && ref_ll && ((a & ~32'h3) == ref_link);
      exp_req = (n > 0) && !mis && (o != OP_SC || sc_ok);
      drive_op(o, a, d, cd, ra, rw);
      if (exp_req) begin
        total++; if (mem_req !== 1'b1 || mem_we !== is_store(o) || mem_be !== ref_be(o, a)) begin bad++;
          $display("FAIL rnd_req[%0d] op=%h a=%h got req=%b we=%b be=%b want 1/%b/%b", i, o, a, mem_req, mem_we, mem_be, is_store(o), ref_be(o, a)); end
        if (is_store(o)) begin
          total++; if (mem_wdata !== ref_wdata(o, d)) begin bad++;
            $display("FAIL rnd_wdata[%0d] got=%h want=%h", i, mem_wdata, ref_wdata(o, d)); end
        end
        wait_ack(dly, rd, st);
        total++; if (st != dly || out_valid !== 1'b1) begin bad++;
          $display("FAIL rnd_done[%0d] got stall=%0d ov=%b want %0d/1", i, st, out_valid, dly); end
        total++; if (reg_wr !== ((is_load(o) || o == OP_SC) ? rw : 1'b0)) begin bad++;
          $display("FAIL rnd_wr[%0d] op=%h got=%b", i, o, reg_wr); end
        if (is_load(o)) begin
          total++; if (reg_data !== ref_load(o, a, rd)) begin bad++;
            $display("FAIL rnd_load[%0d] op=%h a=%h got=%h want=%h", i, o, a, reg_data, ref_load(o, a, rd)); end
        end else if (o == OP_SC) begin
          total++; if (reg_data !== 32'd1) begin bad++; $display("FAIL rnd_sc[%0d] got=%h want=1", i, reg_data); end
        end
        if (o == OP_LL) begin ref_ll = 1'b1; ref_link = a & ~32'h3; end
        if (is_store(o) && (a & ~32'h3) == ref_link) ref_ll = 1'b0;
      end else begin
        total++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || excp_align !== mis) begin bad++;
          $display("FAIL rnd_noreq[%0d] op=%h a=%h got req=%b ov=%b ex=%b want 0/1/%b", i, o, a, mem_req, out_valid, excp_align, mis); end
        if (!mis) begin
          total++; if (reg_data !== ((n == 0) ? cd : 32'd0) || reg_wr !== rw) begin bad++;
            $display("FAIL rnd_wb[%0d] op=%h got %h/%b", i, o, reg_data, reg_wr); end
        end
      end
      total++; if (llbit !== ref_ll) begin bad++;
        $display("FAIL rnd_llbit[%0d] got=%b want=%b", i, llbit, ref_ll); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; mem_addr_i = '0; mem_data = '0;
    regc_data = '0; regc_addr = '0; regc_wr = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_passthrough();
    test_lb_lane();
    test_sh_store();
    test_misalign();
    test_ll_sc();
    test_link_clear();
    test_flush_req();
    test_timeout();
    test_rst_in_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
